// File: rtl/con_mem_loader_pkg.sv
// Shared types and constants for the console memory loader.
// Holds the FSM state encoding, the full-word strobe and the header range check.
package con_mem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLen0  = 3'd1,
        StLen1  = 3'd2,
        StData  = 3'd3,
        StWrite = 3'd4,
        StDone  = 3'd5
    } con_state_e;

    localparam logic [3:0]  CON_WE_ALL = 4'hF;
    localparam int unsigned CON_ADDR_W = 10;

    // True when a session of len words starting at base stays inside a 2**addr_w word memory.
    function automatic logic hdr_fits(input logic [15:0] len, input int unsigned base,
                                      input int unsigned addr_w);
        logic [32:0] end_addr;
        logic [32:0] depth;
        end_addr = 33'(base) + 33'(len);
        depth    = 33'(1) << addr_w;
        return end_addr <= depth;
    endfunction

endpackage

// File: rtl/con_word_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word.
// word_full flags the accept that completes the current word.
module con_word_packer (
    input  logic        CLK,
    input  logic        nrst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            byte_cnt_q <= 2'd0;
            word_q     <= 32'h0;
        end else if (clear) begin
            byte_cnt_q <= 2'd0;
        end else if (accept) begin
            word_q[{byte_cnt_q, 3'b000} +: 8] <= data;
            byte_cnt_q                        <= byte_cnt_q + 2'd1;
        end
    end

    assign word      = word_q;
    assign word_full = accept && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/con_mem_loader.sv
// Loads a length-prefixed little-endian word stream into core memory via the console port,
// holding the core in reset until the final word has been written.
module con_mem_loader
    import con_mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = CON_ADDR_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              nrst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [3:0]        con_write,
    output logic [ADDR_W-1:0] con_addr,
    output logic [31:0]       con_in,
    output logic              core_nrst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    con_state_e        state_q;
    logic [15:0]       len_q;
    logic [15:0]       word_idx_q;
    logic [3:0]        con_write_q;
    logic [ADDR_W-1:0] con_addr_q;
    logic              core_nrst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic        xfer;
    logic [15:0] len_full;
    logic        hdr_ok;
    logic        last_word;
    logic        pk_clear;
    logic        pk_accept;
    logic [31:0] pk_word;
    logic        pk_full;

    assign s_ready   = (state_q == StLen0) || (state_q == StLen1) || (state_q == StData);
    assign xfer      = s_valid && s_ready;
    assign len_full  = {s_data, len_q[7:0]};
    assign hdr_ok    = hdr_fits(len_full, BASE_ADDR, ADDR_W);
    assign last_word = (word_idx_q == (len_q - 16'd1));

    always_comb begin
        pk_accept = (state_q == StData) && xfer;
        pk_clear  = 1'b0;
        if ((state_q == StLen1) && xfer && (len_full != 16'd0) && hdr_ok) begin
            pk_clear = 1'b1;
        end
        if ((state_q == StWrite) && !last_word) begin
            pk_clear = 1'b1;
        end
    end

    con_word_packer u_packer (
        .CLK       (CLK),
        .nrst      (nrst),
        .clear     (pk_clear),
        .accept    (pk_accept),
        .data      (s_data),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_ff @(posedge CLK) begin
        if (!nrst) begin
            state_q     <= StIdle;
            len_q       <= 16'd0;
            word_idx_q  <= 16'd0;
            con_write_q <= 4'h0;
            con_addr_q  <= '0;
            core_nrst_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StLen0;
                    end
                end
                StLen0: begin
                    if (xfer) begin
                        len_q[7:0] <= s_data;
                        state_q    <= StLen1;
                    end
                end
                StLen1: begin
                    if (xfer) begin
                        len_q[15:8] <= s_data;
                        if (len_full == 16'd0) begin
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            core_nrst_q <= 1'b1;
                            state_q     <= StDone;
                        end else if (!hdr_ok) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            word_idx_q <= 16'd0;
                            state_q    <= StData;
                        end
                    end
                end
                StData: begin
                    if (pk_full) begin
                        con_write_q <= CON_WE_ALL;
                        con_addr_q  <= ADDR_W'(BASE_ADDR + 32'(word_idx_q));
                        state_q     <= StWrite;
                    end
                end
                StWrite: begin
                    con_write_q <= 4'h0;
                    if (last_word) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        core_nrst_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        word_idx_q <= word_idx_q + 16'd1;
                        state_q    <= StData;
                    end
                end
                StDone: begin
                    // Restarting pulls the core back into reset before the new image arrives.
                    if (start) begin
                        core_nrst_q <= 1'b0;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StLen0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign con_write = con_write_q;
    assign con_addr  = con_addr_q;
    assign con_in    = pk_word;
    assign core_nrst = core_nrst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_con_mem_loader.sv
// Directed bench for con_mem_loader: single word, gapped multi-word, empty image,
// oversize header and reset mid-session, with a bench-side memory standing in for the core.
module tb_con_mem_loader;

    logic        CLK;
    logic        nrst;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  con_write;
    logic [9:0]  con_addr;
    logic [31:0] con_in;
    logic        core_nrst;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec;
    int n_err;

    logic [31:0] mem [0:1023];
    logic [9:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    logic [3:0]  wr_we [$];
    int          wr_rdy_bad;

    logic [31:0] key [0:2];

    con_mem_loader #(
        .ADDR_W    (10),
        .BASE_ADDR (0)
    ) dut (
        .CLK       (CLK),
        .nrst      (nrst),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .con_write (con_write),
        .con_addr  (con_addr),
        .con_in    (con_in),
        .core_nrst (core_nrst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Core-memory stand-in: record every write strobe seen mid-cycle.
    initial begin
        wr_rdy_bad = 0;
        forever begin
            @(negedge CLK);
            if (con_write != 4'h0) begin
                wr_addr.push_back(con_addr);
                wr_data.push_back(con_in);
                wr_we.push_back(con_write);
                mem[con_addr] = con_in;
                if (s_ready) wr_rdy_bad = wr_rdy_bad + 1;
            end
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_we.delete();
        wr_rdy_bad = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
        s_data  = b;
        s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_byte_timeout: byte %h not accepted, s_ready=%b want 1", b, s_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL wait_done: done=%b after %0d cycles, want 1", done, budget);
        end
    endtask

    task automatic send_scenario3(input int max_gap);
        send_byte(8'h03, max_gap);
        send_byte(8'h00, max_gap);
        for (int i = 0; i < 3; i++) send_word(key[i], max_gap);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        n_vec++;
        if ({con_write, con_addr, con_in} !== 46'h0) begin
            n_err++;
            $display("FAIL reset_port: we=%h addr=%h in=%h want 0", con_write, con_addr, con_in);
        end
        n_vec++;
        if ({s_ready, core_nrst, busy, done, err} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_ctrl: rdy/cnrst/busy/done/err=%b want 00000",
                     {s_ready, core_nrst, busy, done, err});
        end
        @(posedge CLK);
        #1;
        nrst = 1'b1;
    endtask

    task automatic test_single_word();
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hDEADBEEF, 0);
        @(negedge CLK);
        n_vec++;
        if ({con_write, con_addr, con_in} !== {4'hF, 10'd0, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL single_write: we=%h addr=%h in=%h want F/000/deadbeef",
                     con_write, con_addr, con_in);
        end
        n_vec++;
        if (s_ready !== 1'b0 || core_nrst !== 1'b0) begin
            n_err++;
            $display("FAIL single_write_ctrl: s_ready=%b core_nrst=%b want 0/0", s_ready, core_nrst);
        end
        @(negedge CLK);
        n_vec++;
        if ({con_write, done, core_nrst, busy} !== {4'h0, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL single_done: we=%h done=%b cnrst=%b busy=%b want 0/1/1/0",
                     con_write, done, core_nrst, busy);
        end
        n_vec++;
        if (wr_we.size() != 1) begin
            n_err++;
            $display("FAIL single_count: %0d writes want 1", wr_we.size());
        end
    endtask

    task automatic test_multi_word();
        clear_log();
        pulse_start();
        @(negedge CLK);
        n_vec++;
        if ({core_nrst, busy, done} !== 3'b010) begin
            n_err++;
            $display("FAIL restart_ctrl: cnrst/busy/done=%b want 010", {core_nrst, busy, done});
        end
        send_scenario3(3);
        wait_done(200);
        n_vec++;
        if (wr_we.size() != 3) begin
            n_err++;
            $display("FAIL multi_count: %0d writes want 3", wr_we.size());
        end
        for (int i = 0; i < 3 && i < wr_we.size(); i++) begin
            n_vec++;
            if ({wr_we[i], wr_addr[i], wr_data[i]} !== {4'hF, 10'(i), key[i]}) begin
                n_err++;
                $display("FAIL multi_write%0d: we=%h addr=%h data=%h want F/%h/%h",
                         i, wr_we[i], wr_addr[i], wr_data[i], 10'(i), key[i]);
            end
        end
        n_vec++;
        if (wr_rdy_bad != 0) begin
            n_err++;
            $display("FAIL multi_ready_in_write: %0d write cycles with s_ready=1 want 0", wr_rdy_bad);
        end
        n_vec++;
        if (core_nrst !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL multi_release: cnrst=%b busy=%b want 1/0", core_nrst, busy);
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL zero_busy: busy=%b want 1", busy);
        end
        pulse_start();
        send_byte(8'h00, 0);
        @(negedge CLK);
        n_vec++;
        if ({done, busy, core_nrst, err} !== 4'b1010) begin
            n_err++;
            $display("FAIL zero_done: done/busy/cnrst/err=%b want 1010", {done, busy, core_nrst, err});
        end
        repeat (3) @(negedge CLK);
        n_vec++;
        if (done !== 1'b1 || wr_we.size() != 0) begin
            n_err++;
            $display("FAIL zero_sticky: done=%b writes=%0d want 1/0", done, wr_we.size());
        end
    endtask

    task automatic test_len_error();
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        @(negedge CLK);
        n_vec++;
        if ({err, busy, done, core_nrst, s_ready} !== 5'b10000) begin
            n_err++;
            $display("FAIL len_err: err/busy/done/cnrst/rdy=%b want 10000",
                     {err, busy, done, core_nrst, s_ready});
        end
        repeat (4) @(negedge CLK);
        n_vec++;
        if (err !== 1'b1 || core_nrst !== 1'b0 || wr_we.size() != 0) begin
            n_err++;
            $display("FAIL len_err_hold: err=%b cnrst=%b writes=%0d want 1/0/0",
                     err, core_nrst, wr_we.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset_mid();
        clear_log();
        pulse_start();
        @(negedge CLK);
        n_vec++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_start: err=%b busy=%b want 0/1", err, busy);
        end
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        nrst = 1'b0;
        @(posedge CLK);
        #1;
        nrst = 1'b1;
        @(negedge CLK);
        n_vec++;
        if ({con_write, con_addr, con_in, s_ready, core_nrst, busy, done, err} !== 51'h0) begin
            n_err++;
            $display("FAIL mid_reset: we=%h addr=%h in=%h ctrl=%b want all 0", con_write, con_addr,
                     con_in, {s_ready, core_nrst, busy, done, err});
        end
        repeat (10) @(negedge CLK);
        n_vec++;
        if (wr_we.size() != 0) begin
            n_err++;
            $display("FAIL mid_no_write: %0d writes want 0", wr_we.size());
        end
        for (int i = 0; i < 3; i++) mem[i] = 'x;
        @(posedge CLK);
        #1;
        pulse_start();
        send_scenario3(0);
        wait_done(200);
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (mem[i] !== key[i]) begin
                n_err++;
                $display("FAIL readback%0d: mem=%h want %h", i, mem[i], key[i]);
            end
        end
        n_vec++;
        if (con_addr !== 10'd2 || con_write !== 4'h0) begin
            n_err++;
            $display("FAIL addr_hold: addr=%h we=%h want 002/0", con_addr, con_write);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        nrst    = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        key[0]  = 32'h00000013;
        key[1]  = 32'h00100093;
        key[2]  = 32'h00208113;
        test_reset();
        test_single_word();
        test_multi_word();
        test_zero_len();
        test_len_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
